mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the memory's second read port (raddr1/rdata1) and its single write port between two requesters. Requester 0 is the CPU data stage and requester 1 is an auxiliary master (loader/DMA/debug). The read port and the write port are arbitrated independently, each with its own round-robin pointer, so one read and one write from different requesters can both issue in the same cycle. Read responses are routed back to their owner after the fixed memory read latency.

Parameters:
ADDR_W, 32, address width of requests and memory ports
DATA_W, 32, data width
RD_LAT, 1, memory read latency in cycles from raddr to rdata; legal range 1..4

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
r0_valid  input  1  requester 0 has a request
r0_we  input  1  1 = write, 0 = read
r0_addr  input  ADDR_W  request address
r0_wdata  input  DATA_W  write data
r0_ready  output  1  request accepted this cycle
r0_rvalid  output  1  read data valid for requester 0
r0_rdata  output  DATA_W  read data
r1_valid, r1_we, r1_addr, r1_wdata, r1_ready, r1_rvalid, r1_rdata  same as requester 0, for requester 1
mem_raddr  output  ADDR_W  to mem raddr1
mem_rdata  input  DATA_W  from mem rdata1
mem_wen  output  1  to mem wen
mem_waddr  output  ADDR_W  to mem waddr
mem_wdata  output  DATA_W  to mem wdata

Behaviour:
- Handshake: a request transfers in a cycle where valid=1 and ready=1. ready is combinational from the valid/we inputs and the pointers. A requester holds valid, we, addr and wdata stable until ready. The arbiter does not check this.
- Read port: candidates are the requesters with valid=1 and we=0.
  - One candidate: it is granted.
  - Two candidates: the grant goes to the requester other than rd_last. rd_last updates to the granted requester.
- Write port: the same rule with we=1 and its own pointer, wr_last.
- A read and a write from different requesters are both granted in the same cycle. At most one grant per port per cycle, so each requester gets at most one grant per cycle.
- Write grant: mem_wen=1, mem_waddr and mem_wdata taken from the winner in the same cycle. No write grant: mem_wen=0, mem_waddr=0, mem_wdata=0.
- Read grant: mem_raddr = the winner's addr in the same cycle. No read grant: mem_raddr=0.
- Response tracking: a shift register of RD_LAT stages, each holding {valid, owner}. A read grant enters {1, winner} and idle cycles enter {0, x}. The stage leaving after RD_LAT cycles drives rN_rvalid=1 for its owner. rN_rdata = mem_rdata when rN_rvalid=1, else 0.
- Read latency is exactly RD_LAT cycles from the handshake to rvalid. Responses return in grant order. There is no outstanding limit: one read may issue every cycle.
- Same-address read and write in the same cycle: no forwarding. The read returns whatever mem returns, which is mem's defined behaviour.
- Reset, synchronous: rd_last=1 and wr_last=1 (requester 0 wins the first conflict on each port). All tracking stages are cleared.
- Reset values of outputs: all rvalid=0, all rdata=0. While reset=1: all ready=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0.
- Reset mid-operation: in-flight reads are discarded and produce no rvalid, even if mem returns data afterwards.
- Pointers change only on a contested grant, i.e. both requesters competing for the same port. An uncontested grant leaves the pointer unchanged.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds three outputs, each 32 bits, all cleared by reset and all saturating at 0xFFFFFFFF:
  - stat_grants0: increments once per cycle in which requester 0 gets any grant.
  - stat_grants1: the same for requester 1.
  - stat_stalls: increments once per cycle in which at least one valid requester has ready=0.
- Undefined: these outputs and counters are absent. All other behaviour is identical.

Test Plan:
- Single read: RD_LAT=1, r0 reads 0x100, mem returns 0xDEADBEEF. Expect r0_ready=1 and mem_raddr=0x100 in the same cycle. Next cycle r0_rvalid=1 and r0_rdata=0xDEADBEEF; r1_rvalid stays 0.
- Read contention: after reset, r0 and r1 both read continuously (0x10, 0x20) for 4 cycles. Expect grants r0, r1, r0, r1 and rvalid alternating r0/r1 one cycle later.
- Parallel ports: r0 writes 0x55 to 0x40 while r1 reads 0x80 in the same cycle. Expect both ready=1, mem_wen=1, mem_waddr=0x40, mem_raddr=0x80; r1_rvalid=1 after RD_LAT.
- Write contention: r0 and r1 both write (0x1→0x8 and 0x2→0xC). Expect r0 granted first with mem_wdata=0x1, then r1 with 0x2; the loser's ready=0 while blocked.
- Reset mid-read: RD_LAT=3, r1 read granted, reset asserted for 1 cycle the next cycle. Expect no r1_rvalid at any later cycle; the first contested grant afterwards goes to r0.
- Stats, with MEM_ARB_STATS_EN: run the 4-cycle read-contention scenario. Expect stat_grants0=2, stat_grants1=2, stat_stalls=4.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared memory read port and write port, each with its own
// round-robin pointer. Optional grant/stall counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]       stat_grants0,
  output logic [31:0]       stat_grants1,
  output logic [31:0]       stat_stalls,
`endif
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  logic rd_c0, rd_c1, wr_c0, wr_c1;
  logic rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;
  logic rd_last_q, rd_last_d, wr_last_q, wr_last_d;
  logic [RD_LAT-1:0] trk_vld_q, trk_vld_d, trk_own_q, trk_own_d;

  // A pointer value of 1 means requester 1 won the last contest, so requester 0 wins the next.
  always_comb begin
    rd_c0     = r0_valid & ~r0_we;
    rd_c1     = r1_valid & ~r1_we;
    wr_c0     = r0_valid & r0_we;
    wr_c1     = r1_valid & r1_we;
    rd_gnt0   = 1'b0;
    rd_gnt1   = 1'b0;
    wr_gnt0   = 1'b0;
    wr_gnt1   = 1'b0;
    rd_last_d = rd_last_q;
    wr_last_d = wr_last_q;
    if (!reset) begin
      if (rd_c0 && rd_c1) begin
        rd_gnt0   = rd_last_q;
        rd_gnt1   = ~rd_last_q;
        rd_last_d = ~rd_last_q;
      end else begin
        rd_gnt0 = rd_c0;
        rd_gnt1 = rd_c1;
      end
      if (wr_c0 && wr_c1) begin
        wr_gnt0   = wr_last_q;
        wr_gnt1   = ~wr_last_q;
        wr_last_d = ~wr_last_q;
      end else begin
        wr_gnt0 = wr_c0;
        wr_gnt1 = wr_c1;
      end
    end
  end

  assign r0_ready  = rd_gnt0 | wr_gnt0;
  assign r1_ready  = rd_gnt1 | wr_gnt1;
  assign mem_raddr = rd_gnt0 ? r0_addr : (rd_gnt1 ? r1_addr : '0);
  assign mem_wen   = wr_gnt0 | wr_gnt1;
  assign mem_waddr = wr_gnt0 ? r0_addr : (wr_gnt1 ? r1_addr : '0);
  assign mem_wdata = wr_gnt0 ? r0_wdata : (wr_gnt1 ? r1_wdata : '0);

  // Response tracker: stage 0 takes the current read grant, the top stage lines up with mem_rdata.
  always_comb begin
    trk_vld_d = RD_LAT'({trk_vld_q, rd_gnt0 | rd_gnt1});
    trk_own_d = RD_LAT'({trk_own_q, rd_gnt1});
  end

  assign r0_rvalid = ~reset & trk_vld_q[RD_LAT-1] & ~trk_own_q[RD_LAT-1];
  assign r1_rvalid = ~reset & trk_vld_q[RD_LAT-1] & trk_own_q[RD_LAT-1];
  assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
  assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_last_q <= 1'b1;
      wr_last_q <= 1'b1;
      trk_vld_q <= '0;
      trk_own_q <= '0;
    end else begin
      rd_last_q <= rd_last_d;
      wr_last_q <= wr_last_d;
      trk_vld_q <= trk_vld_d;
      trk_own_q <= trk_own_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  localparam int unsigned STAT_W = 32;

  logic              stall_c;
  logic [STAT_W-1:0] grants0_q, grants0_d, grants1_q, grants1_d, stalls_q, stalls_d;

  // Saturating counters; a stall is any cycle where a valid requester is held off.
  always_comb begin
    stall_c   = (r0_valid & ~r0_ready) | (r1_valid & ~r1_ready);
    grants0_d = grants0_q;
    grants1_d = grants1_q;
    stalls_d  = stalls_q;
    if (r0_ready && (grants0_q != '1)) grants0_d = grants0_q + STAT_W'(1);
    if (r1_ready && (grants1_q != '1)) grants1_d = grants1_q + STAT_W'(1);
    if (stall_c && (stalls_q != '1))   stalls_d  = stalls_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grants0_q <= '0;
      grants1_q <= '0;
      stalls_q  <= '0;
    end else begin
      grants0_q <= grants0_d;
      grants1_q <= grants1_d;
      stalls_q  <= stalls_d;
    end
  end

  assign stat_grants0 = grants0_q;
  assign stat_grants1 = grants1_q;
  assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus and are checked
// every cycle against a queue-based reference model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          r0_valid, r0_we, r1_valid, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, mem_rdata;

  logic          a_r0_ready, a_r0_rvalid, a_r1_ready, a_r1_rvalid, a_mem_wen;
  logic [DW-1:0] a_r0_rdata, a_r1_rdata, a_mem_wdata;
  logic [AW-1:0] a_mem_raddr, a_mem_waddr;
  logic          b_r0_ready, b_r0_rvalid, b_r1_ready, b_r1_rvalid, b_mem_wen;
  logic [DW-1:0] b_r0_rdata, b_r1_rdata, b_mem_wdata;
  logic [AW-1:0] b_mem_raddr, b_mem_waddr;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   a_sg0, a_sg1, a_sst, b_sg0, b_sg1, b_sst;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(a_r0_ready), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(a_r1_ready), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
`ifdef MEM_ARB_STATS_EN
    .stat_grants0(a_sg0), .stat_grants1(a_sg1), .stat_stalls(a_sst),
`endif
    .mem_raddr(a_mem_raddr), .mem_rdata(mem_rdata), .mem_wen(a_mem_wen),
    .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(b_r0_ready), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(b_r1_ready), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
`ifdef MEM_ARB_STATS_EN
    .stat_grants0(b_sg0), .stat_grants1(b_sg1), .stat_stalls(b_sst),
`endif
    .mem_raddr(b_mem_raddr), .mem_rdata(mem_rdata), .mem_wen(b_mem_wen),
    .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata)
  );

  logic [164:0] obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {a_r0_ready, a_r1_ready, a_mem_wen, a_mem_waddr, a_mem_wdata, a_mem_raddr,
                  a_r0_rvalid, a_r0_rdata, a_r1_rvalid, a_r1_rdata};
  assign obs_b = {b_r0_ready, b_r1_ready, b_mem_wen, b_mem_waddr, b_mem_wdata, b_mem_raddr,
                  b_r0_rvalid, b_r0_rdata, b_r1_rvalid, b_r1_rdata};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_last = 1;
  int wr_last = 1;
  int rw, ww;
  bit rd_both, wr_both;
  int q1_due[$], q1_own[$], q3_due[$], q3_own[$];
  int st_g0, st_g1, st_st;

  // Winner of one port: a lone candidate wins, a contest goes to the one that did not win last.
  function automatic int pick(bit c0, bit c1, int last);
    if (c0 && c1) return (last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic model_eval();
    bit c0r, c1r, c0w, c1w;
    int oa, ob;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] wdata;
    c0r = r0_valid && !r0_we;
    c1r = r1_valid && !r1_we;
    c0w = r0_valid && r0_we;
    c1w = r1_valid && r1_we;
    rd_both = !reset && c0r && c1r;
    wr_both = !reset && c0w && c1w;
    if (reset) begin
      rw = -1;
      ww = -1;
    end else begin
      rw = pick(c0r, c1r, rd_last);
      ww = pick(c0w, c1w, wr_last);
    end
    raddr = (rw == 0) ? r0_addr : ((rw == 1) ? r1_addr : '0);
    waddr = (ww == 0) ? r0_addr : ((ww == 1) ? r1_addr : '0);
    wdata = (ww == 0) ? r0_wdata : ((ww == 1) ? r1_wdata : '0);
    oa = -1;
    ob = -1;
    if (!reset && q1_due.size() > 0 && q1_due[0] == cyc) oa = q1_own[0];
    if (!reset && q3_due.size() > 0 && q3_due[0] == cyc) ob = q3_own[0];
    exp_a = {(rw == 0 || ww == 0), (rw == 1 || ww == 1), (ww >= 0), waddr, wdata, raddr,
             (oa == 0), (oa == 0) ? mem_rdata : {DW{1'b0}},
             (oa == 1), (oa == 1) ? mem_rdata : {DW{1'b0}}};
    exp_b = {(rw == 0 || ww == 0), (rw == 1 || ww == 1), (ww >= 0), waddr, wdata, raddr,
             (ob == 0), (ob == 0) ? mem_rdata : {DW{1'b0}},
             (ob == 1), (ob == 1) ? mem_rdata : {DW{1'b0}}};
  endtask

  task automatic model_commit();
    if (reset) begin
      rd_last = 1;
      wr_last = 1;
      q1_due.delete(); q1_own.delete(); q3_due.delete(); q3_own.delete();
      st_g0 = 0; st_g1 = 0; st_st = 0;
    end else begin
      if (q1_due.size() > 0 && q1_due[0] == cyc) begin
        void'(q1_due.pop_front()); void'(q1_own.pop_front());
      end
      if (q3_due.size() > 0 && q3_due[0] == cyc) begin
        void'(q3_due.pop_front()); void'(q3_own.pop_front());
      end
      if (rw >= 0) begin
        q1_due.push_back(cyc + 1); q1_own.push_back(rw);
        q3_due.push_back(cyc + 3); q3_own.push_back(rw);
        if (rd_both) rd_last = rw;
      end
      if (ww >= 0 && wr_both) wr_last = ww;
      if (rw == 0 || ww == 0) st_g0++;
      if (rw == 1 || ww == 1) st_g1++;
      if ((r0_valid && !(rw == 0 || ww == 0)) || (r1_valid && !(rw == 1 || ww == 1))) st_st++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic apply_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      r0_valid = 1'($urandom); r0_we = 1'($urandom); r0_addr = $urandom; r0_wdata = $urandom;
      r1_valid = 1'($urandom); r1_we = 1'($urandom); r1_addr = $urandom; r1_wdata = $urandom;
      mem_rdata = $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL reset lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL reset lat3 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
      tick();
    end
    reset = 1'b0;
    set_idle();
  endtask

  task automatic test_single_read();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      if (c == 0) begin r0_valid = 1'b1; r0_addr = 32'h100; end
      mem_rdata = (c == 1) ? 32'hDEADBEEF : $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL single_read lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL single_read lat3 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
      tick();
    end
  endtask

  task automatic test_read_contention();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c < 4) begin
        r0_valid = 1'b1; r0_addr = 32'h10;
        r1_valid = 1'b1; r1_addr = 32'h20;
      end
      mem_rdata = $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL read_contention lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL read_contention lat3 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
      tick();
    end
  endtask

  task automatic test_parallel_ports();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      if (c == 0) begin
        r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 32'h40; r0_wdata = 32'h55;
        r1_valid = 1'b1; r1_addr = 32'h80;
      end
      mem_rdata = $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL parallel lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL parallel lat3 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
      tick();
    end
  endtask

  task automatic test_write_contention();
    bit p0, p1, g0, g1;
    apply_reset();
    p0 = 1'b1;
    p1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_idle();
      r0_valid = p0; r0_we = 1'b1; r0_addr = 32'h8; r0_wdata = 32'h1;
      r1_valid = p1; r1_we = 1'b1; r1_addr = 32'hC; r1_wdata = 32'h2;
      mem_rdata = $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL write_contention lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL write_contention lat3 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
      g0 = (ww == 0);
      g1 = (ww == 1);
      tick();
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      set_idle();
      reset = (c == 1);
      if (c == 0) begin r1_valid = 1'b1; r1_addr = 32'h30; end
      if (c == 6) begin
        r0_valid = 1'b1; r0_addr = 32'h44;
        r1_valid = 1'b1; r1_addr = 32'h48;
      end
      mem_rdata = $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL reset_mid_read lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL reset_mid_read lat3 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit p0, p1, g0, g1;
    apply_reset();
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1'b1; r0_we = 1'($urandom); r0_addr = 32'($urandom_range(0, 15)) << 2; r0_wdata = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1'b1; r1_we = 1'($urandom); r1_addr = 32'($urandom_range(0, 15)) << 2; r1_wdata = $urandom;
      end
      r0_valid = p0;
      r1_valid = p1;
      mem_rdata = $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL random lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      total++;
      if (obs_b !== exp_b) begin bad++; $display("FAIL random lat3 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
      g0 = (rw == 0 || ww == 0);
      g1 = (rw == 1 || ww == 1);
      tick();
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    reset = 1'b0;
    set_idle();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      set_idle();
      r0_valid = 1'b1; r0_addr = 32'h10;
      r1_valid = 1'b1; r1_addr = 32'h20;
      mem_rdata = $urandom;
      #2; model_eval();
      total++;
      if (obs_a !== exp_a) begin bad++; $display("FAIL stats_traffic lat1 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      tick();
    end
    set_idle();
    #2;
    total++;
    if ({a_sg0, a_sg1, a_sst} !== {32'(st_g0), 32'(st_g1), 32'(st_st)}) begin
      bad++; $display("FAIL stats lat1 got=%0d/%0d/%0d exp=%0d/%0d/%0d", a_sg0, a_sg1, a_sst, st_g0, st_g1, st_st);
    end
    total++;
    if ({b_sg0, b_sg1, b_sst} !== {32'(st_g0), 32'(st_g1), 32'(st_st)}) begin
      bad++; $display("FAIL stats lat3 got=%0d/%0d/%0d exp=%0d/%0d/%0d", b_sg0, b_sg1, b_sst, st_g0, st_g1, st_st);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    mem_rdata = '0;
    set_idle();
    #1;
    test_reset();
    test_single_read();
    test_read_contention();
    test_parallel_ports();
    test_write_contention();
    test_reset_mid_read();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
